// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and instruction field positions for the fetch unit
package fetch_pkg;
  typedef enum logic {REQ, ISSUE} fetch_state_t;
  localparam int COND_MSB    = 31;
  localparam int OP_LSB      = 26;
  localparam int FUNCT_LSB   = 20;
  localparam int RD_LSB      = 12;
  localparam int PC_STEP     = 4;
  localparam int PC_READ_OFS = 8;
endpackage

// File: rtl/registro_pc.sv
// registro_pc: program counter register with branch/sequential next-PC select
//  clk, rst_n            clock, async active-low reset (pc <= RESET_PC)
//  load                  issue handshake; pc advances only when high
//  PC_src, branch_target word-aligned branch target taken when PC_src=1, else pc+4
//  pc                    current PC
module registro_pc import fetch_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              PC_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);
  // Low two bits are cleared so the PC always stays word aligned.
  logic [ADDR_W-1:0] target;
  assign target = branch_target & ~ADDR_W'(3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (load) pc <= PC_src ? target : pc + ADDR_W'(PC_STEP);
endmodule

// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch front end with imem req/ready and instr valid/ready handshakes
//  clk, rst_n                     clock, async active-low reset
//  imem_req/addr/ready/rdata      instruction memory request interface (addr = pc)
//  instr_valid/ready              issue handshake toward the control unit
//  instr, cond, op, funct, rd     instruction register and its decoded fields
//  pc, pc_plus8                   address of IR and architectural PC read value
//  PC_src, branch_target          redirect, sampled only on the issue handshake
//  instr_count                    issued-instruction counter
module unidad_fetch import fetch_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         cond,
  output logic [1:0]         op,
  output logic [5:0]         funct,
  output logic [3:0]         rd,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus8,
  input  logic               PC_src,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [31:0]        instr_count
);
  fetch_state_t state, state_n;
  logic issue;
  assign issue = instr_valid & instr_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= REQ;
    else state <= state_n;
  // Request is gated by rst_n so it stays low while reset is held even though the state is REQ.
  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if (state == REQ) begin
      imem_req = rst_n;
      state_n  = imem_ready ? ISSUE : REQ;
    end else begin
      instr_valid = 1'b1;
      state_n     = instr_ready ? REQ : ISSUE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instr <= '0;
    else if (state == REQ && imem_ready) instr <= imem_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instr_count <= '0;
    else if (issue) instr_count <= instr_count + 32'd1;
  registro_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .load(issue), .PC_src(PC_src),
    .branch_target(branch_target), .pc(pc)
  );
  assign imem_addr = pc;
  assign pc_plus8  = pc + ADDR_W'(PC_READ_OFS);
  assign cond      = instr[COND_MSB -: 4];
  assign op        = instr[OP_LSB +: 2];
  assign funct     = instr[FUNCT_LSB +: 6];
  assign rd        = instr[RD_LSB +: 4];
endmodule
